// File: rtl/addr_init_pkg.sv
// Shared types and constants for the address-load initiator that drives the
// strobed bank/auto-increment address bus.
package addr_init_pkg;

   localparam int AWIDTH_DEF = 17;
   localparam int DWIDTH_DEF = 8;
   localparam int LWIDTH_DEF = 8;

   localparam logic [2:0] BSEL_B0   = 3'b000;
   localparam logic [2:0] BSEL_B1   = 3'b001;
   localparam logic [2:0] BSEL_B2   = 3'b010;
   localparam logic [2:0] BSEL_NONE = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      LD0,
      LD1,
      LD2,
      BEAT_WAIT,
      BEAT,
      FIN
   } ainitState_t;

   // Banks are always visited in ascending order; once none remain the
   // request either moves on to data beats or finishes outright.
   function automatic ainitState_t pickNext(input logic [2:0] need, input logic lenZero);
      if (need[0])
         return LD0;
      else if (need[1])
         return LD1;
      else if (need[2])
         return LD2;
      else if (lenZero)
         return FIN;
      else
         return BEAT_WAIT;
   endfunction

endpackage

// File: rtl/addr_load_initiator_strobe_phaser.sv
// Generates one bus strobe: SETUP_CYC high cycles, then LOW_CYC low cycles.
// fallPulse/donePulse flag the cycle before the falling and rising edges.
module strobe_phaser #(
   parameter int SETUP_CYC = 1,
   parameter int LOW_CYC   = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic strbN,
   output logic fallPulse,
   output logic donePulse
);

   localparam int TOTAL = SETUP_CYC + LOW_CYC;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] FALL_IDX = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   logic          active;
   logic [CW-1:0] cnt;
   logic [CW-1:0] idx;
   logic          running;

   // start is high during the first cycle of a strobe, so that cycle is index 0
   assign running   = start | active;
   assign idx       = start ? '0 : cnt;
   assign fallPulse = running && (idx == FALL_IDX);
   assign donePulse = running && (idx == LAST_IDX);

   // StrbN is a plain register so the bus never sees a combinational glitch.
   always_ff @(posedge clock) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
         strbN  <= 1'b1;
      end else if (running) begin
         if (donePulse) begin
            active <= 1'b0;
            cnt    <= '0;
            strbN  <= 1'b1;
         end else begin
            active <= 1'b1;
            cnt    <= idx + 1'b1;
            if (fallPulse)
               strbN <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/addr_load_initiator.sv
// Host-side master for the strobed address-controller bus: loads changed
// address banks, then issues one auto-increment strobe per data beat.
module addr_load_initiator
   import addr_init_pkg::*;
#(
   parameter int AWIDTH         = AWIDTH_DEF,
   parameter int DWIDTH         = DWIDTH_DEF,
   parameter int LWIDTH         = LWIDTH_DEF,
   parameter int SETUP_CYC      = 1,
   parameter int LOW_CYC        = 2,
   parameter int SKIP_UNCHANGED = 1
) (
   input  logic              AINIT_Clk,
   input  logic              AINIT_Rst,
   input  logic              AINIT_Req_Valid,
   output logic              AINIT_Req_Ready,
   input  logic [AWIDTH-1:0] AINIT_Req_Addr,
   input  logic [LWIDTH-1:0] AINIT_Req_Len,
   input  logic              AINIT_Beat_Valid,
   output logic              AINIT_Beat_Ready,
   input  logic [DWIDTH-1:0] AINIT_Beat_Data,
   output logic              AINIT_Done,
   output logic              AINIT_StrbN,
   output logic [2:0]        AINIT_BSel,
   output logic [DWIDTH-1:0] AINIT_Data_Out,
   output logic              AINIT_Inc
);

   ainitState_t       state;
   ainitState_t       nextState;
   logic [AWIDTH-1:0] addrReg;
   logic [AWIDTH-1:0] curAddr;
   logic [AWIDTH-1:0] shadow;
   logic              shadowValid;
   logic [LWIDTH-1:0] lenRem;
   logic [2:0]        needLd;
   logic [2:0]        needNew;
   logic              lenZero;
   logic              startStrb;
   logic              fallPulse;
   logic              donePulse;

   function automatic logic [DWIDTH-1:0] bankByte(input logic [AWIDTH-1:0] a, input int bank);
      case (bank)
         0:       return DWIDTH'(a[7:0]);
         1:       return DWIDTH'(a[15:8]);
         default: return DWIDTH'(a[AWIDTH-1:16]);
      endcase
   endfunction

   strobe_phaser #(
      .SETUP_CYC (SETUP_CYC),
      .LOW_CYC   (LOW_CYC)
   ) uPhaser (
      .clock     (AINIT_Clk),
      .reset     (AINIT_Rst),
      .start     (startStrb),
      .strbN     (AINIT_StrbN),
      .fallPulse (fallPulse),
      .donePulse (donePulse)
   );

   assign AINIT_Req_Ready  = (state == IDLE) && AINIT_Req_Valid && !AINIT_Rst;
   assign AINIT_Beat_Ready = (state == BEAT_WAIT) && AINIT_Beat_Valid && !AINIT_Rst;

   // Bank skip decisions compare the shadow against the incoming request, and
   // the next state is chosen here so the registered outputs can follow it.
   always_comb begin
      curAddr   = (state == IDLE) ? AINIT_Req_Addr : addrReg;
      lenZero   = (state == IDLE) ? (AINIT_Req_Len == '0) : (lenRem == '0);
      needNew   = '0;
      for (int b = 0; b < 3; b++)
         needNew[b] = !((SKIP_UNCHANGED != 0) && shadowValid &&
                        (bankByte(shadow, b) == bankByte(AINIT_Req_Addr, b)));
      nextState = state;
      case (state)
         IDLE:      if (AINIT_Req_Valid) nextState = pickNext(needNew, lenZero);
         LD0:       if (donePulse) nextState = pickNext(needLd & 3'b110, lenZero);
         LD1:       if (donePulse) nextState = pickNext(needLd & 3'b100, lenZero);
         LD2:       if (donePulse) nextState = pickNext(3'b000, lenZero);
         BEAT_WAIT: if (AINIT_Beat_Valid) nextState = BEAT;
         BEAT:      if (donePulse) nextState = (lenRem == LWIDTH'(1)) ? FIN : BEAT_WAIT;
         FIN:       nextState = IDLE;
         default:   nextState = IDLE;
      endcase
   end

   // Bus values are set on entry to a state and held for the whole strobe;
   // the shadow tracks the target by applying each change at its falling edge.
   always_ff @(posedge AINIT_Clk) begin
      if (AINIT_Rst) begin
         state          <= IDLE;
         addrReg        <= '0;
         lenRem         <= '0;
         needLd         <= '0;
         shadow         <= '0;
         shadowValid    <= 1'b0;
         startStrb      <= 1'b0;
         AINIT_Done     <= 1'b0;
         AINIT_BSel     <= BSEL_NONE;
         AINIT_Data_Out <= '0;
         AINIT_Inc      <= 1'b0;
      end else begin
         state      <= nextState;
         startStrb  <= 1'b0;
         AINIT_Done <= 1'b0;

         if ((state == IDLE) && AINIT_Req_Valid) begin
            addrReg <= AINIT_Req_Addr;
            lenRem  <= AINIT_Req_Len;
            needLd  <= needNew;
         end

         if (fallPulse) begin
            case (state)
               LD0:     shadow[7:0]         <= addrReg[7:0];
               LD1:     shadow[15:8]        <= addrReg[15:8];
               LD2:     shadow[AWIDTH-1:16] <= addrReg[AWIDTH-1:16];
               BEAT:    shadow              <= shadow + 1'b1;
               default: ;
            endcase
         end

         if ((state == BEAT) && donePulse)
            lenRem <= lenRem - 1'b1;

         if ((state inside {IDLE, LD0, LD1, LD2}) && (nextState inside {BEAT_WAIT, FIN}))
            shadowValid <= 1'b1;

         if (nextState != state) begin
            case (nextState)
               LD0: begin
                  AINIT_BSel     <= BSEL_B0;
                  AINIT_Data_Out <= bankByte(curAddr, 0);
                  AINIT_Inc      <= 1'b0;
                  startStrb      <= 1'b1;
               end
               LD1: begin
                  AINIT_BSel     <= BSEL_B1;
                  AINIT_Data_Out <= bankByte(curAddr, 1);
                  AINIT_Inc      <= 1'b0;
                  startStrb      <= 1'b1;
               end
               LD2: begin
                  AINIT_BSel     <= BSEL_B2;
                  AINIT_Data_Out <= bankByte(curAddr, 2);
                  AINIT_Inc      <= 1'b0;
                  startStrb      <= 1'b1;
               end
               BEAT: begin
                  AINIT_BSel     <= BSEL_NONE;
                  AINIT_Data_Out <= AINIT_Beat_Data;
                  AINIT_Inc      <= 1'b1;
                  startStrb      <= 1'b1;
               end
               FIN: begin
                  AINIT_BSel <= BSEL_NONE;
                  AINIT_Inc  <= 1'b0;
                  AINIT_Done <= 1'b1;
               end
               default: begin
                  AINIT_BSel <= BSEL_NONE;
                  AINIT_Inc  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_addr_load_initiator.sv
// Bench for addr_load_initiator: a bus-level target model and protocol monitor
// check directed and random requests, beat stalls and a mid-strobe reset.
module tb_addr_load_initiator;

   localparam int S = 2;
   localparam int L = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic [16:0] reqAddr = '0;
   logic [7:0]  reqLen = '0;
   logic        beatValid = 1'b0;
   logic        beatReady;
   logic [7:0]  beatData = '0;
   logic        done;
   logic        strbN;
   logic [2:0]  bsel;
   logic [7:0]  dataOut;
   logic        inc;

   always #5 clock = ~clock;

   addr_load_initiator #(
      .AWIDTH(17), .DWIDTH(8), .LWIDTH(8),
      .SETUP_CYC(S), .LOW_CYC(L), .SKIP_UNCHANGED(1)
   ) dut (
      .AINIT_Clk        (clock),
      .AINIT_Rst        (reset),
      .AINIT_Req_Valid  (reqValid),
      .AINIT_Req_Ready  (reqReady),
      .AINIT_Req_Addr   (reqAddr),
      .AINIT_Req_Len    (reqLen),
      .AINIT_Beat_Valid (beatValid),
      .AINIT_Beat_Ready (beatReady),
      .AINIT_Beat_Data  (beatData),
      .AINIT_Done       (done),
      .AINIT_StrbN      (strbN),
      .AINIT_BSel       (bsel),
      .AINIT_Data_Out   (dataOut),
      .AINIT_Inc        (inc)
   );

   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Target model and bus protocol monitor, sampled on the falling clock edge.
   logic [16:0] tgt = '0;
   int          loadFalls = 0, incFalls = 0, fallCnt = 0, doneCnt = 0, beatRdyCnt = 0;
   int          highCnt = 100, lowCnt = 0, stableCnt = 0;
   logic        prevStrbN = 1'b1;
   logic [11:0] prevVals = '0, fallVals = '0;
   logic [7:0]  beatQ[$];

   always @(negedge clock) begin
      logic [11:0] cur;
      cur = {bsel, dataOut, inc};
      if (cur == prevVals) stableCnt++; else stableCnt = 1;
      if (!strbN && prevStrbN) begin
         fallVals = cur;
         fallCnt++;
         if (!reset) begin
            checkOutput("setupHigh", 32'(highCnt >= S), 1);
            checkOutput("setupStable", 32'(stableCnt >= S + 1), 1);
            checkOutput("legalCombo", 32'(((bsel inside {3'b000, 3'b001, 3'b010}) && !inc) ||
                                          ((bsel == 3'b111) && inc)), 1);
         end
         case (bsel)
            3'b000:  tgt[7:0]  = dataOut;
            3'b001:  tgt[15:8] = dataOut;
            3'b010:  tgt[16]   = dataOut[0];
            default: ;
         endcase
         if (inc) tgt = tgt + 17'd1;
         if (bsel != 3'b111) loadFalls++;
         if (inc) begin
            incFalls++;
            if (beatQ.size() == 0) checkOutput("beatQueueEmpty", 0, 1);
            else checkOutput("beatData", 32'(dataOut), 32'(beatQ.pop_front()));
         end
         lowCnt = 1;
      end else if (!strbN) begin
         lowCnt++;
         if (!reset) checkOutput("lowStable", 32'(cur), 32'(fallVals));
      end else if (!prevStrbN) begin
         if (!reset) checkOutput("lowLength", lowCnt, L);
         highCnt = 1;
      end else begin
         highCnt++;
      end
      prevStrbN = strbN;
      prevVals  = cur;
   end

   // Handshake outputs are combinational, so they are sampled just before the rising edge.
   always begin
      @(negedge clock);
      #4;
      if (beatReady) beatRdyCnt++;
      if (done) doneCnt++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  len;
      int          gap;
      int          expLoads;
      logic [16:0] expFinal;
   } vec_t;

   vec_t        vecs[$];
   logic [16:0] mShadow = '0;
   logic        mValid = 1'b0;

   function automatic int modelLoads(input logic [16:0] a);
      if (!mValid) return 3;
      return int'(a[7:0] != mShadow[7:0]) + int'(a[15:8] != mShadow[15:8]) + int'(a[16] != mShadow[16]);
   endfunction

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic addVec(input logic [16:0] a, input logic [7:0] ln, input int gap,
                         input int expLoads, input logic [16:0] expFinal);
      vec_t v;
      v.addr = a; v.len = ln; v.gap = gap; v.expLoads = expLoads; v.expFinal = expFinal;
      vecs.push_back(v);
      mShadow = expFinal;
      mValid  = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc;
      logic ok;
      tick();
      loadFalls = 0; incFalls = 0; doneCnt = 0; beatRdyCnt = 0;
      reqValid = 1'b1; reqAddr = v.addr; reqLen = v.len;
      #1;
      cyc = 0;
      while (!reqReady && cyc < 20) begin tick(); cyc++; end
      checkOutput("reqReady", 32'(reqReady), 1);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < int'(v.len); i++) begin
         if (i == 1 && v.gap > 0) begin
            cyc = 0;
            while ((incFalls < 1 || !strbN) && cyc < 50) begin tick(); cyc++; end
            ok = 1'b1;
            for (int g = 0; g < v.gap; g++) begin
               tick();
               if (!strbN || bsel != 3'b111) ok = 1'b0;
            end
            checkOutput("stallIdle", 32'(ok), 1);
         end
         beatData  = 8'($urandom);
         beatValid = 1'b1;
         beatQ.push_back(beatData);
         #1;
         cyc = 0;
         while (!beatReady && cyc < 50) begin tick(); cyc++; end
         if (cyc >= 50) checkOutput("beatTimeout", 0, 1);
         tick();
         beatValid = 1'b0;
      end
      cyc = 0;
      while (doneCnt == 0 && cyc < 100) begin tick(); cyc++; end
      repeat (4) tick();
      checkOutput("donePulses", doneCnt, 1);
      checkOutput("loadStrobes", loadFalls, v.expLoads);
      checkOutput("incStrobes", incFalls, 32'(v.len));
      checkOutput("beatReadyPulses", beatRdyCnt, 32'(v.len));
      checkOutput("targetAddr", 32'(tgt), 32'(v.expFinal));
   endtask

   initial begin
      logic [16:0] a;
      logic [7:0]  ln;
      int          cyc;
      int          fallsBefore;
      logic        found;
      vec_t        v;

      // Directed vectors first, then random ones whose expectations come from the model.
      addVec(17'h1A5C3, 8'd0,   0,  3, 17'h1A5C3);
      addVec(17'h1A5C7, 8'd2,   0,  1, 17'h1A5C9);
      addVec(17'h1FFFE, 8'd3,   0,  2, 17'h00001);
      addVec(17'h00001, 8'd0,   0,  0, 17'h00001);
      addVec(17'h00001, 8'd2,   10, 0, 17'h00003);
      addVec(17'h1FF80, 8'd255, 0,  3, 17'h0007F);
      for (int k = 0; k < 10; k++) begin
         case ($urandom % 3)
            0:       a = 17'($urandom);
            1:       a = {mShadow[16:8], 8'($urandom)};
            default: a = mShadow;
         endcase
         ln = 8'($urandom % 6);
         addVec(a, ln, ($urandom % 2) ? 3 : 0, modelLoads(a), a + 17'(ln));
      end

      repeat (3) tick();
      checkOutput("rstStrbN", 32'(strbN), 1);
      checkOutput("rstBSel", 32'(bsel), 32'h7);
      checkOutput("rstData", 32'(dataOut), 0);
      checkOutput("rstInc", 32'(inc), 0);
      checkOutput("rstDone", 32'(done), 0);
      checkOutput("rstReqReady", 32'(reqReady), 0);
      checkOutput("rstBeatReady", 32'(beatReady), 0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Reset while an Inc strobe is low.
      tick();
      doneCnt = 0;
      reqValid = 1'b1; reqAddr = 17'h0ABCD; reqLen = 8'd3;
      beatData = 8'h5A; beatValid = 1'b1;
      repeat (3) beatQ.push_back(8'h5A);
      #1;
      checkOutput("midReqReady", 32'(reqReady), 1);
      tick();
      reqValid = 1'b0;
      found = 1'b0;
      cyc = 0;
      while (!found && cyc < 200) begin
         tick();
         cyc++;
         if (!strbN && inc) found = 1'b1;
      end
      checkOutput("midFoundLowInc", 32'(found), 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midRstStrbN", 32'(strbN), 1);
      checkOutput("midRstBSel", 32'(bsel), 32'h7);
      checkOutput("midRstInc", 32'(inc), 0);
      fallsBefore = fallCnt;
      tick();
      tick();
      reset = 1'b0;
      beatValid = 1'b0;
      repeat (10) tick();
      checkOutput("midNoDone", doneCnt, 0);
      checkOutput("midNoFall", fallCnt, fallsBefore);
      beatQ.delete();
      mValid = 1'b0;

      v.addr = 17'h00005; v.len = 8'd1; v.gap = 0;
      v.expLoads = modelLoads(v.addr);
      v.expFinal = v.addr + 17'(v.len);
      applyStimulus(v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
